// File: rtl/clock_display_driver_if.sv
// Time inputs from digitalclock and multiplexed display outputs of clock_display_driver.
// The master side supplies the time and observes the display; the driver is the slave.
interface clock_display_driver_if;
  logic [5:0] seconds;
  logic [5:0] minutes;
  logic [4:0] hours;
  logic [5:0] an;
  logic [6:0] seg;
  logic       dp;
  logic       frame_start;

  modport master (
    output seconds, minutes, hours,
    input  an, seg, dp, frame_start
  );

  modport slave (
    input  seconds, minutes, hours,
    output an, seg, dp, frame_start
  );
endinterface

// File: rtl/clock_display_driver.sv
// Six-digit multiplexed seven-segment driver for HH:MM:SS with per-frame snapshot,
// anti-ghosting guard interval, leading-zero blanking and a blinking colon.
module clock_display_driver #(
  parameter int SCAN_DIV = 1000,
  parameter int GUARD    = 1,
  parameter int BLANK_LZ = 1
) (
  input  logic                   Clk,
  input  logic                   reset,
  clock_display_driver_if.slave  bus
);

  localparam logic [15:0] P_LAST  = 16'(SCAN_DIV - 1);
  localparam logic [15:0] GUARD_W = 16'(GUARD);
  localparam logic [6:0]  SEG_BLANK = 7'b1111111;
  localparam logic [6:0]  SEG_DASH  = 7'b0111111;

  logic [15:0] p_q, p_d;
  logic [2:0]  d_q, d_d;
  logic [5:0]  s_q, s_d;
  logic [5:0]  m_q, m_d;
  logic [4:0]  h_q, h_d;

  logic [5:0]  an_q, an_d;
  logic [6:0]  seg_q, seg_d;
  logic        dp_q, dp_d;
  logic        frame_start_q, frame_start_d;

  logic        tick_s;
  logic        load_s;
  logic        guard_ok_s;

  logic [7:0]  sec_bcd_s, min_bcd_s, hr_bcd_s;
  logic        s_ok_s, m_ok_s, h_ok_s;
  logic [3:0]  digit_s;
  logic        field_ok_s;
  logic        lz_s;

  // Split 0..63 into {tens, ones} with a compare/subtract ladder; tens saturates at 6.
  function automatic logic [7:0] split_bcd(input logic [5:0] v);
    logic [3:0] tens;
    logic [3:0] ones;
    if (v >= 6'd60) begin
      tens = 4'd6; ones = 4'(v - 6'd60);
    end else if (v >= 6'd50) begin
      tens = 4'd5; ones = 4'(v - 6'd50);
    end else if (v >= 6'd40) begin
      tens = 4'd4; ones = 4'(v - 6'd40);
    end else if (v >= 6'd30) begin
      tens = 4'd3; ones = 4'(v - 6'd30);
    end else if (v >= 6'd20) begin
      tens = 4'd2; ones = 4'(v - 6'd20);
    end else if (v >= 6'd10) begin
      tens = 4'd1; ones = 4'(v - 6'd10);
    end else begin
      tens = 4'd0; ones = v[3:0];
    end
    return {tens, ones};
  endfunction

  function automatic logic [6:0] seg_code(input logic [3:0] digit);
    logic [6:0] code;
    case (digit)
      4'd0:    code = 7'b1000000;
      4'd1:    code = 7'b1111001;
      4'd2:    code = 7'b0100100;
      4'd3:    code = 7'b0110000;
      4'd4:    code = 7'b0011001;
      4'd5:    code = 7'b0010010;
      4'd6:    code = 7'b0000010;
      4'd7:    code = 7'b1111000;
      4'd8:    code = 7'b0000000;
      4'd9:    code = 7'b0010000;
      default: code = SEG_BLANK;
    endcase
    return code;
  endfunction

  assign tick_s = (p_q == P_LAST);
  assign load_s = tick_s && (d_q == 3'd5);

  // With no guard interval every slot position is lit; avoids a constant compare.
  if (GUARD == 0) begin : g_no_guard
    assign guard_ok_s = 1'b1;
  end else begin : g_guard
    assign guard_ok_s = (p_q >= GUARD_W);
  end

  // Scan state register: prescaler, digit index and the frame snapshot.
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      p_q <= 16'd0;
      d_q <= 3'd0;
      s_q <= 6'd0;
      m_q <= 6'd0;
      h_q <= 5'd0;
    end else begin
      p_q <= p_d;
      d_q <= d_d;
      s_q <= s_d;
      m_q <= m_d;
      h_q <= h_d;
    end
  end

  // Next scan state; the snapshot reloads on the edge where the digit index wraps.
  always_comb begin
    p_d = tick_s ? 16'd0 : (p_q + 16'd1);
    d_d = d_q;
    if (tick_s) begin
      d_d = (d_q == 3'd5) ? 3'd0 : (d_q + 3'd1);
    end else begin
      d_d = d_q;
    end
    if (load_s) begin
      s_d = bus.seconds;
      m_d = bus.minutes;
      h_d = bus.hours;
    end else begin
      s_d = s_q;
      m_d = m_q;
      h_d = h_q;
    end
  end

  // Decode the current slot into next-cycle display values.
  always_comb begin
    sec_bcd_s = split_bcd(s_q);
    min_bcd_s = split_bcd(m_q);
    hr_bcd_s  = split_bcd({1'b0, h_q});
    s_ok_s    = (s_q <= 6'd59);
    m_ok_s    = (m_q <= 6'd59);
    h_ok_s    = (h_q <= 5'd23);
    digit_s    = 4'd0;
    field_ok_s = 1'b0;
    lz_s       = 1'b0;
    case (d_q)
      3'd0: begin digit_s = sec_bcd_s[3:0]; field_ok_s = s_ok_s; end
      3'd1: begin digit_s = sec_bcd_s[7:4]; field_ok_s = s_ok_s; end
      3'd2: begin digit_s = min_bcd_s[3:0]; field_ok_s = m_ok_s; end
      3'd3: begin digit_s = min_bcd_s[7:4]; field_ok_s = m_ok_s; end
      3'd4: begin digit_s = hr_bcd_s[3:0];  field_ok_s = h_ok_s; end
      3'd5: begin
        digit_s    = hr_bcd_s[7:4];
        field_ok_s = h_ok_s;
        lz_s       = (BLANK_LZ != 0) && (hr_bcd_s[7:4] == 4'd0);
      end
      default: begin digit_s = 4'd0; field_ok_s = 1'b0; end
    endcase

    if (!field_ok_s) begin
      seg_d = SEG_DASH;
    end else if (lz_s) begin
      seg_d = SEG_BLANK;
    end else begin
      seg_d = seg_code(digit_s);
    end

    an_d = guard_ok_s ? ~(6'b000001 << d_q) : 6'b111111;
    // Colon sits on the minutes-ones and hours-ones slots, blinking with seconds.
    dp_d = (((d_q == 3'd2) || (d_q == 3'd4)) && !s_q[0]) ? 1'b0 : 1'b1;
    frame_start_d = load_s;
  end

  // Output register: one cycle of latency after the scan state.
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      an_q          <= 6'b111111;
      seg_q         <= 7'b1111111;
      dp_q          <= 1'b1;
      frame_start_q <= 1'b0;
    end else begin
      an_q          <= an_d;
      seg_q         <= seg_d;
      dp_q          <= dp_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign bus.an          = an_q;
  assign bus.seg         = seg_q;
  assign bus.dp          = dp_q;
  assign bus.frame_start = frame_start_q;

endmodule

// File: tb/tb_clock_display_driver.sv
// Directed bench for clock_display_driver: three instances cover BLANK_LZ on/off and
// the no-guard fast-scan configuration, driven from one table of per-frame vectors.
module tb_clock_display_driver;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] t_sec;
  logic [5:0] t_min;
  logic [4:0] t_hr;

  always #5 clk = ~clk;

  clock_display_driver_if if_a ();
  clock_display_driver_if if_b ();
  clock_display_driver_if if_c ();

  assign if_a.seconds = t_sec;
  assign if_a.minutes = t_min;
  assign if_a.hours   = t_hr;
  assign if_b.seconds = t_sec;
  assign if_b.minutes = t_min;
  assign if_b.hours   = t_hr;
  assign if_c.seconds = t_sec;
  assign if_c.minutes = t_min;
  assign if_c.hours   = t_hr;

  clock_display_driver #(.SCAN_DIV(4), .GUARD(1), .BLANK_LZ(1)) dut_a (
    .Clk(clk), .reset(rst_n), .bus(if_a));
  clock_display_driver #(.SCAN_DIV(4), .GUARD(1), .BLANK_LZ(0)) dut_b (
    .Clk(clk), .reset(rst_n), .bus(if_b));
  clock_display_driver #(.SCAN_DIV(2), .GUARD(0), .BLANK_LZ(1)) clock_display_driver (
    .Clk(clk), .reset(rst_n), .bus(if_c));

  typedef struct packed {
    logic [5:0]      sec;
    logic [5:0]      min;
    logic [4:0]      hr;
    logic [5:0][6:0] seg_a;   // index = digit
    logic [6:0]      seg5_b;  // hours-tens with blanking disabled
    logic [5:0]      dp_n;    // expected dp per digit
  } vec_t;

  vec_t vecs [5];
  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_an_a"},  {26'd0, if_a.an},  32'h3f);
    chk({tag, "_seg_a"}, {25'd0, if_a.seg}, 32'h7f);
    chk({tag, "_dp_a"},  {31'd0, if_a.dp},  32'd1);
    chk({tag, "_fs_a"},  {31'd0, if_a.frame_start}, 32'd0);
    chk({tag, "_an_c"},  {26'd0, if_c.an},  32'h3f);
    chk({tag, "_seg_c"}, {25'd0, if_c.seg}, 32'h7f);
    chk({tag, "_fs_c"},  {31'd0, if_c.frame_start}, 32'd0);
  endtask

  initial begin
    logic [5:0] exp_an;
    logic [5:0] exp_an_c;
    int j;

    // Frame 0: reset snapshot 00:00:00
    vecs[0] = '{sec: 6'd0, min: 6'd0, hr: 5'd0,
                seg_a: {7'b1111111, 7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000},
                seg5_b: 7'b1000000, dp_n: 6'b101011};
    // Frame 1: 12:34:56
    vecs[1] = '{sec: 6'd56, min: 6'd34, hr: 5'd12,
                seg_a: {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001, 7'b0010010, 7'b0000010},
                seg5_b: 7'b1111001, dp_n: 6'b101011};
    // Frame 2: 13:00:00 (applied mid frame 1)
    vecs[2] = '{sec: 6'd0, min: 6'd0, hr: 5'd13,
                seg_a: {7'b1111001, 7'b0110000, 7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000},
                seg5_b: 7'b1111001, dp_n: 6'b101011};
    // Frame 3: out-of-range seconds and hours
    vecs[3] = '{sec: 6'd60, min: 6'd5, hr: 5'd24,
                seg_a: {7'b0111111, 7'b0111111, 7'b1000000, 7'b0010010, 7'b0111111, 7'b0111111},
                seg5_b: 7'b0111111, dp_n: 6'b101011};
    // Frame 4: 07:00:01, odd seconds so no colon
    vecs[4] = '{sec: 6'd1, min: 6'd0, hr: 5'd7,
                seg_a: {7'b1111111, 7'b1111000, 7'b1000000, 7'b1000000, 7'b1000000, 7'b1111001},
                seg5_b: 7'b1000000, dp_n: 6'b111111};

    rst_n = 1'b0;
    t_sec = vecs[1].sec;
    t_min = vecs[1].min;
    t_hr  = vecs[1].hr;
    for (int k = 0; k < 3; k++) begin
      step();
      chk_reset_outputs("hold_rst");
    end

    @(negedge clk);
    rst_n = 1'b1;
    j = 0;

    for (int f = 0; f < 5; f++) begin
      for (int d = 0; d < 6; d++) begin
        for (int p = 0; p < 4; p++) begin
          step();
          j++;
          if (d == 0 && p == 1 && f < 4) begin
            t_sec = vecs[f + 1].sec;
            t_min = vecs[f + 1].min;
            t_hr  = vecs[f + 1].hr;
          end
          exp_an = (p == 0) ? 6'b111111 : ~(6'b000001 << d);
          chk("an_a", {26'd0, if_a.an}, {26'd0, exp_an});
          chk("an_b", {26'd0, if_b.an}, {26'd0, exp_an});
          if (p != 0) begin
            chk("seg_a", {25'd0, if_a.seg}, {25'd0, vecs[f].seg_a[d]});
            chk("dp_a",  {31'd0, if_a.dp},  {31'd0, vecs[f].dp_n[d]});
            if (d == 5) begin
              chk("seg5_b", {25'd0, if_b.seg}, {25'd0, vecs[f].seg5_b});
            end
          end
          chk("fs_a", {31'd0, if_a.frame_start}, {31'd0, (d == 5 && p == 3)});
          chk("fs_b", {31'd0, if_b.frame_start}, {31'd0, (d == 5 && p == 3)});
          exp_an_c = ~(6'b000001 << (((j - 1) / 2) % 6));
          chk("an_c", {26'd0, if_c.an}, {26'd0, exp_an_c});
          chk("fs_c", {31'd0, if_c.frame_start}, {31'd0, (j % 12 == 0)});
        end
      end
    end

    // Abort mid-frame: outputs must go to reset values without waiting for a clock edge.
    for (int k = 0; k < 6; k++) step();
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("mid_rst");
    for (int k = 0; k < 2; k++) begin
      step();
      chk_reset_outputs("mid_rst_hold");
    end

    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 24; k++) begin
      step();
      if (k == 1) begin
        chk("restart_guard_an", {26'd0, if_a.an}, 32'h3f);
      end
      if (k == 2) begin
        chk("restart_an0",  {26'd0, if_a.an},  32'h3e);
        chk("restart_seg0", {25'd0, if_a.seg}, {25'd0, 7'b1000000});
      end
      if (k == 22) begin
        chk("restart_lz_seg5", {25'd0, if_a.seg}, 32'h7f);
        chk("restart_lz_an5",  {26'd0, if_a.an},  {26'd0, 6'b011111});
      end
      chk("restart_fs_a", {31'd0, if_a.frame_start}, {31'd0, (k == 24)});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/clock_display_driver.md
# clock_display_driver

Multiplexed six-digit seven-segment driver that sits directly downstream of `digitalclock`. It consumes the binary `seconds`/`minutes`/`hours` counts and converts each field to two BCD digits. It time-multiplexes the six digits onto one common-anode segment bus, using a fast board clock. Each frame is taken from a snapshot of the time, so a carry (e.g. 12:59:59 → 13:00:00) never shows torn digits.

## Interface
Parameters:
- `SCAN_DIV`, 1000: clock cycles per digit slot; legal range 2..65535.
- `GUARD`, 1: leading cycles of each slot with all digits off (anti-ghosting); legal range 0..SCAN_DIV-1.
- `BLANK_LZ`, 1: 1 = blank the hours-tens digit when it is 0.

Ports:
- `Clk`  in  1: scan clock (board clock, not `Clk_1sec`).
- `reset`  in  1: asynchronous, active-low reset.
- `seconds`  in  6: binary seconds from `digitalclock`; valid range 0..59.
- `minutes`  in  6: binary minutes; valid range 0..59.
- `hours`  in  5: binary hours; valid range 0..23.
- `an`  out  6: digit enables, active-low. `an[0]` = seconds ones, up to `an[5]` = hours tens.
- `seg`  out  7: segments {g,f,e,d,c,b,a}, active-low.
- `dp`  out  1: decimal point, active-low; used as the colon.
- `frame_start`  out  1: one-cycle pulse when a new snapshot is loaded.

## Operation
- Prescaler `p` counts 0..SCAN_DIV-1 and wraps. `tick` = (`p` == SCAN_DIV-1).
- Digit index `d` counts 0..5 and advances on `tick`. It wraps 5→0.
- Snapshot registers (`s`, `m`, `h`) load `seconds`/`minutes`/`hours` on the `tick` where `d` == 5, i.e. the same edge on which `d` becomes 0. All digits of a frame come from one snapshot. Input changes mid-frame are invisible until the next frame.
- Field decode:
  - tens = v/10 and ones = v%10, computed by compare/subtract; no divider.
  - A field out of range (`s`>59, `m`>59, `h`>23) shows dash `0111111` on both of its digits.
- Digit mapping:
  - `d`=0: `s` ones; `d`=1: `s` tens.
  - `d`=2: `m` ones; `d`=3: `m` tens.
  - `d`=4: `h` ones; `d`=5: `h` tens.
- Segment codes:
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001
  - 5 = 0010010, 6 = 0000010, 7 = 1111000, 8 = 0000000, 9 = 0010000
  - blank = 1111111
- Leading-zero blanking: when BLANK_LZ=1, `d`=5, the hours field is valid and `h` tens = 0, `seg` is blank while `an[5]` is still driven low.
- Colon: `dp`=0 when `d` ∈ {2,4} and `s[0]`=0; otherwise `dp`=1. The colon therefore blinks at 0.5 Hz.
- Digit enable: `an` = ~(1<<`d`) when `p` ≥ GUARD, else 6'b111111.
- `frame_start`=1 for the one cycle after a snapshot load.

## Timing
- Reset values (reset low, asynchronous, immediate):
  - `p`=0, `d`=0, snapshot=0.
  - `an`=111111, `seg`=1111111, `dp`=1, `frame_start`=0.
- Reset asserted mid-frame aborts the scan immediately. After release, scanning restarts at digit 0 with snapshot 0.
- `an`, `seg`, `dp` and `frame_start` are registered, with a latency of exactly one cycle: outputs in cycle n+1 decode `p`, `d` and the snapshot of cycle n.
- After reset release:
  - Frame 0 displays 00:00:00 (hours tens blank if BLANK_LZ=1).
  - The first snapshot load happens on the edge that ends cycle 6·SCAN_DIV-1.
  - `frame_start` is high in the cycle after that edge.
- Frame period is 6·SCAN_DIV cycles. Each digit is lit for SCAN_DIV-GUARD cycles per frame.
- No handshake with `digitalclock`. Inputs are sampled only on the snapshot edge, which must meet setup to `Clk`. Crossing from the `Clk_1sec` domain is the integrator's responsibility.

## Test plan
- Hold reset low with inputs 12:34:56 → `an`=111111, `seg`=1111111, `dp`=1, `frame_start`=0 throughout. Assert reset mid-frame → same values on the same cycle.
- SCAN_DIV=4, GUARD=1, inputs 12:34:56 from reset release:
  - Frame 0 shows 0,0,0,0,0,blank.
  - `frame_start` is high once, 24 cycles after release.
  - Frame 1 shows digits 6,5,4,3,2,1 with `seg` = 0000010, 0010010, 0011001, 0110000, 0100100, 1111001.
  - Each `an` slot is 1 cycle 111111, then 3 cycles of one-hot low.
  - `dp`=0 on digits 2 and 4.
- Change inputs from 12:34:56 to 13:00:00 during frame 1 → all frame-1 digits stay 12:34:56. Frame 2 shows 13:00:00.
- Inputs `seconds`=60, `minutes`=5, `hours`=24 → digits 0,1,4,5 `seg`=0111111; digit 2 = 0010010, digit 3 = 1000000.
- Inputs 07:00:01:
  - BLANK_LZ=1 → digit 5 `seg`=1111111 with `an[5]`=0.
  - BLANK_LZ=0 → digit 5 `seg`=1000000.
  - `dp`=1 on all digits (odd seconds).
- GUARD=0, SCAN_DIV=2 → `an` never shows 111111 after the first cycle following reset release. Frame period is 12 cycles between `frame_start` pulses.
